ddr3_burst_arbiter: RTL

//  Sequences DDR3 traffic between the user write FIFO and read FIFO and the AXI burst master.

---
 rtl/ddr3_burst_arbiter_pkg.sv | 32 +++
 rtl/ddr3_burst_arbiter_if.sv | 38 +++
 rtl/ddr3_burst_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ddr3_burst_arbiter_pkg.sv
// Shared DDR3 controller definitions: arbiter state encoding, grant
// direction, and the burst-geometry helpers that both the arbiter and the
// AXI burst master use to derive STEP and NBURST from their parameters.
package ddr3_burst_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4
    } arb_state_t;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_t;

    // Bytes covered by one burst; also the pointer increment.
    function automatic int unsigned burst_step(input int unsigned burst_len,
                                               input int unsigned beat_bytes);
        return burst_len * beat_bytes;
    endfunction

    // Number of burst slots in the ring region [mem_beg, mem_end).
    function automatic int unsigned burst_count(input int unsigned mem_beg,
                                                input int unsigned mem_end,
                                                input int unsigned step);
        return (mem_end - mem_beg) / step;
    endfunction

endpackage

// File: rtl/ddr3_burst_arbiter_if.sv
// Burst request/acknowledge handshake between the arbiter (master side,
// issues requests) and the AXI burst master (slave side, accepts them).
interface ddr3_burst_arbiter_if #(
    parameter int AXI_ADDR_W = 30
);

    logic                  wr_burst_req;
    logic [AXI_ADDR_W-1:0] wr_burst_addr;
    logic                  wr_burst_ack;
    logic                  wr_burst_done;
    logic                  rd_burst_req;
    logic [AXI_ADDR_W-1:0] rd_burst_addr;
    logic                  rd_burst_ack;
    logic                  rd_burst_done;

    modport master (
        output wr_burst_req,
        output wr_burst_addr,
        input  wr_burst_ack,
        input  wr_burst_done,
        output rd_burst_req,
        output rd_burst_addr,
        input  rd_burst_ack,
        input  rd_burst_done
    );

    modport slave (
        input  wr_burst_req,
        input  wr_burst_addr,
        output wr_burst_ack,
        output wr_burst_done,
        input  rd_burst_req,
        input  rd_burst_addr,
        output rd_burst_ack,
        output rd_burst_done
    );

endinterface

// File: rtl/ddr3_burst_arbiter.sv
// DDR3 burst arbiter: grants one write or read burst at a time between the
// user FIFOs and the AXI burst master, round-robin when both are eligible.
// The memory region is used as a ring of fixed-size burst slots with
// independent write and read pointers and a count of filled slots.
module ddr3_burst_arbiter
    import ddr3_burst_arbiter_pkg::*;
#(
    parameter int          AXI_ADDR_W  = 30,
    parameter int          CNT_W       = 10,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned BEAT_BYTES  = 8,
    parameter int unsigned RD_FIFO_DEP = 512,
    parameter int unsigned MEM_BEG     = 0,
    parameter int unsigned MEM_END     = 'h400
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    calib_done,
    input  logic                    rd_mem_enable,
    input  logic [CNT_W-1:0]        wr_fifo_cnt,
    input  logic [CNT_W-1:0]        rd_fifo_cnt,
    ddr3_burst_arbiter_if.master    bus,
    output logic                    mem_full,
    output logic                    mem_empty,
    output logic                    busy
);

    localparam int unsigned STEP     = burst_step(BURST_LEN, BEAT_BYTES);
    localparam int unsigned NBURST   = burst_count(MEM_BEG, MEM_END, STEP);
    localparam int          STORED_W = $clog2(NBURST + 1);

    // Pointer arithmetic is done one bit wider than the address so the
    // wrap test cannot be fooled by an overflowing sum.
    localparam logic [AXI_ADDR_W:0]   STEP_X    = (AXI_ADDR_W+1)'(STEP);
    localparam logic [AXI_ADDR_W:0]   MEM_END_X = (AXI_ADDR_W+1)'(MEM_END);
    localparam logic [AXI_ADDR_W-1:0] MEM_BEG_A = AXI_ADDR_W'(MEM_BEG);
    localparam logic [STORED_W-1:0]   NBURST_S  = STORED_W'(NBURST);
    localparam logic [STORED_W-1:0]   ONE_S     = STORED_W'(1);

    arb_state_t            state;
    grant_t                last_grant;
    logic [AXI_ADDR_W-1:0] wr_ptr;
    logic [AXI_ADDR_W-1:0] rd_ptr;
    logic [STORED_W-1:0]   stored;
    logic                  wr_req_q;
    logic                  rd_req_q;

    logic                  wr_level_ok;
    logic                  rd_space_ok;
    logic                  wr_ok;
    logic                  rd_ok;

    // Next slot in the ring after ptr, wrapping back to the region start.
    function automatic logic [AXI_ADDR_W-1:0] advance(input logic [AXI_ADDR_W-1:0] ptr);
        logic [AXI_ADDR_W:0] sum;
        sum = {1'b0, ptr} + STEP_X;
        if (sum >= MEM_END_X) begin
            return MEM_BEG_A;
        end
        return sum[AXI_ADDR_W-1:0];
    endfunction

    // Eligibility of each direction; only consulted while idle.
    always_comb begin
        wr_level_ok = 32'(wr_fifo_cnt) >= BURST_LEN;
        rd_space_ok = (32'(rd_fifo_cnt) + BURST_LEN) <= RD_FIFO_DEP;
        wr_ok       = calib_done & wr_level_ok & (stored < NBURST_S);
        rd_ok       = calib_done & rd_mem_enable & (stored != '0) & rd_space_ok;
    end

    // Grant/handshake FSM, also owning the ring pointers and slot count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_READ;
            wr_ptr     <= MEM_BEG_A;
            rd_ptr     <= MEM_BEG_A;
            stored     <= '0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_ok && (!rd_ok || last_grant == GRANT_READ)) begin
                        state      <= ST_WR_REQ;
                        wr_req_q   <= 1'b1;
                        last_grant <= GRANT_WRITE;
                    end else if (rd_ok) begin
                        state      <= ST_RD_REQ;
                        rd_req_q   <= 1'b1;
                        last_grant <= GRANT_READ;
                    end
                end
                ST_WR_REQ: begin
                    if (bus.wr_burst_ack) begin
                        wr_req_q <= 1'b0;
                        if (bus.wr_burst_done) begin
                            state  <= ST_IDLE;
                            wr_ptr <= advance(wr_ptr);
                            stored <= stored + ONE_S;
                        end else begin
                            state <= ST_WR_WAIT;
                        end
                    end
                end
                ST_WR_WAIT: begin
                    if (bus.wr_burst_done) begin
                        state  <= ST_IDLE;
                        wr_ptr <= advance(wr_ptr);
                        stored <= stored + ONE_S;
                    end
                end
                ST_RD_REQ: begin
                    if (bus.rd_burst_ack) begin
                        rd_req_q <= 1'b0;
                        if (bus.rd_burst_done) begin
                            state  <= ST_IDLE;
                            rd_ptr <= advance(rd_ptr);
                            stored <= stored - ONE_S;
                        end else begin
                            state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (bus.rd_burst_done) begin
                        state  <= ST_IDLE;
                        rd_ptr <= advance(rd_ptr);
                        stored <= stored - ONE_S;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wr_req_q <= 1'b0;
                    rd_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_burst_req  = wr_req_q;
    assign bus.wr_burst_addr = wr_ptr;
    assign bus.rd_burst_req  = rd_req_q;
    assign bus.rd_burst_addr = rd_ptr;

    assign mem_full  = (stored == NBURST_S);
    assign mem_empty = (stored == '0);
    assign busy      = (state != ST_IDLE);

endmodule
